// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants for the register-file writeback controller.
//   - requester index constants (LSU / ALU / debug)
//   - register address width, register count, default data width
//   - helper for the width of a requester index
package regfile_wb_ctrl_pkg;

  // Requester slot assignment on the writeback bus
  localparam int unsigned REQ_LSU  = 0;
  localparam int unsigned REQ_ALU  = 1;
  localparam int unsigned REQ_DBG  = 2;

  // Default bus geometry
  localparam int unsigned NREQ_DEF = 3;
  localparam int unsigned XLEN_DEF = 32;

  // Architectural register file
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  // Width of an index into n requesters; never zero so the index register exists
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : regfile_wb_ctrl_pkg

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback request bus between the requesters (LSU, ALU, debug) and the
// writeback controller.
//   req_valid_i  [NREQ]         request valid, one bit per requester
//   req_ready_o  [NREQ]         grant, one-hot or zero, combinational
//   req_rd_i     [NREQ*5]       destination register, requester i at [5i+4:5i]
//   req_data_i   [NREQ*XLEN]    write data, requester i at [XLEN*i +: XLEN]
// master: requester side; slave: controller side.
interface regfile_wb_ctrl_if
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned XLEN = XLEN_DEF
) ();

  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [NREQ*REG_AW-1:0] req_rd_i;
  logic [NREQ*XLEN-1:0]   req_data_i;

  modport master (
    output req_valid_i,
    output req_rd_i,
    output req_data_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_rd_i,
    input  req_data_i,
    output req_ready_o
  );

endinterface : regfile_wb_ctrl_if

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Purely combinational round-robin picker.
//   req        [NREQ]   request vector
//   last_grant [IDX_W]  index of the most recently accepted requester
//   grant      [NREQ]   one-hot grant (zero when no request)
// The search starts at (last_grant + 1) mod NREQ and wraps around.
module rr_arbiter
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NREQ-1:0]  grant
);

  int unsigned start_idx;
  int unsigned cand_idx;
  logic        found;

  // Walk offsets 1..NREQ from last_grant; first requesting slot wins
  always_comb begin
    grant     = '0;
    found     = 1'b0;
    cand_idx  = 0;
    start_idx = 32'(last_grant);
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand_idx = start_idx + k;
      if (cand_idx >= NREQ) begin
        cand_idx = cand_idx - NREQ;
      end
      // Constant-index scan keeps every select statically bounded
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && (cand_idx == i) && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller with pending-write scoreboard.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wb (slave)            writeback request bus (valid/ready/rd/data per requester)
//   alloc_valid_i/rd_i    issue marks a destination register pending
//   flush_i               drop all pending marks
//   rs1/rs2_addr_i        source registers to check
//   rs1/rs2_busy_o        source has a pending write (combinational)
//   reg_write_o           register-file write enable (registered)
//   rd_addr_o             register-file write address (registered)
//   write_data_o          register-file write data (registered)
//   alloc_err_o           one-cycle pulse: allocation to an already-busy register
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_wb_ctrl_if.slave  wb,
  input  logic              alloc_valid_i,
  input  logic [REG_AW-1:0] alloc_rd_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              reg_write_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic [XLEN-1:0]   write_data_o,
  output logic              alloc_err_o
);

  localparam int unsigned IDX_W = idx_width(NREQ);

  logic [NREQ-1:0]     grant;
  logic [IDX_W-1:0]    last_grant_q;
  logic                accept;
  logic [IDX_W-1:0]    sel_idx;
  logic [REG_AW-1:0]   sel_rd;
  logic [XLEN-1:0]     sel_data;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                alloc_hit;
  logic                alloc_clearing;
  logic                alloc_err_nxt;

  // Round-robin grant selection
  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req        (wb.req_valid_i),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Grant only ever lands on a valid bit, so any grant is an acceptance
  assign wb.req_ready_o = grant;
  assign accept         = |grant;

  // Mux the granted requester's rd/data onto the write path
  always_comb begin
    sel_idx  = '0;
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_idx  = IDX_W'(i);
        sel_rd   = wb.req_rd_i[REG_AW*i +: REG_AW];
        sel_data = wb.req_data_i[XLEN*i +: XLEN];
      end
    end
  end

  // Arbiter pointer only moves on an accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IDX_W'(NREQ - 1);
    end else if (accept) begin
      last_grant_q <= sel_idx;
    end
  end

  // Output stage: address/data follow every acceptance, x0 writes are suppressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_o  <= 1'b0;
      rd_addr_o    <= '0;
      write_data_o <= '0;
    end else begin
      reg_write_o <= accept && (sel_rd != '0);
      if (accept) begin
        rd_addr_o    <= sel_rd;
        write_data_o <= sel_data;
      end
    end
  end

  assign alloc_hit      = alloc_valid_i && (alloc_rd_i != '0);
  assign alloc_clearing = reg_write_o && (rd_addr_o == alloc_rd_i);

  // Scoreboard next state: commit clears, alloc sets over it, flush beats both
  always_comb begin
    busy_nxt = busy_q;
    if (reg_write_o) begin
      busy_nxt[rd_addr_o] = 1'b0;
    end
    if (alloc_hit) begin
      busy_nxt[alloc_rd_i] = 1'b1;
    end
    if (flush_i) begin
      busy_nxt = '0;
    end
    busy_nxt[0] = 1'b0;
  end

  // Double allocation: bit already set and not being released on this edge
  assign alloc_err_nxt = alloc_hit && busy_q[alloc_rd_i] && !alloc_clearing && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      alloc_err_o <= 1'b0;
    end else begin
      busy_q      <= busy_nxt;
      alloc_err_o <= alloc_err_nxt;
    end
  end

  // Hazard lookup; x0 reads zero because busy_q[0] never sets
  assign rs1_busy_o = busy_q[rs1_addr_i];
  assign rs2_busy_o = busy_q[rs2_addr_i];

endmodule : regfile_wb_ctrl

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 Parameter NREQ, default 3, number of writeback requesters (index 0 = LSU, 1 = ALU, 2 = debug).
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  NREQ  writeback request valid, one bit per requester.
REQ-006 req_ready_o  output  NREQ  grant/ready, one-hot or zero.
REQ-007 req_rd_i  input  NREQ*5  destination register per requester, requester i in bits [5i+4:5i].
REQ-008 req_data_i  input  NREQ*XLEN  write data per requester, requester i in bits [XLEN*i+XLEN-1:XLEN*i].
REQ-009 alloc_valid_i  input  1  issue stage marks a destination register pending.
REQ-010 alloc_rd_i  input  5  register being allocated.
REQ-011 flush_i  input  1  discard all pending marks.
REQ-012 rs1_addr_i, rs2_addr_i  input  5 each  source registers to check.
REQ-013 rs1_busy_o, rs2_busy_o  output  1 each  source has a pending write.
REQ-014 reg_write_o  output  1  register-file write enable.
REQ-015 rd_addr_o  output  5  register-file write address.
REQ-016 write_data_o  output  XLEN  register-file write data.
REQ-017 alloc_err_o  output  1  one-cycle pulse: allocation to an already-busy register.

Function
REQ-018 Handshake: requester i is accepted in a cycle iff req_valid_i[i] && req_ready_o[i].
REQ-019 req_ready_o: combinational; at most one bit high; bit high only if that requester is valid.
REQ-020 Arbitration: round-robin, search starts at (last_grant+1) mod NREQ; last_grant updates only on an accepted request; last_grant resets to NREQ-1, so requester 0 wins first.
REQ-021 Holding valid without ready is legal; rd and data must stay stable until acceptance; the arbiter never drops a pending request.
REQ-022 Output stage: registered; the cycle after acceptance, reg_write_o=1, rd_addr_o=accepted rd, write_data_o=accepted data; latency exactly 1 cycle; throughput one write per cycle.
REQ-023 No acceptance in a cycle -> reg_write_o=0 next cycle; rd_addr_o/write_data_o hold their previous values.
REQ-024 Accepted request with rd=0: handshake completes, but reg_write_o stays 0 next cycle.
REQ-025 Scoreboard: 32-bit busy vector; bit 0 is hardwired to 0.
REQ-026 alloc_valid_i with alloc_rd_i!=0 sets busy[alloc_rd_i] at the next edge.
REQ-027 Busy clear: busy[rd_addr_o] clears at the edge where reg_write_o=1, which is the same edge the register file commits the write.
REQ-028 Same-edge alloc and clear of the same register: alloc wins and the bit stays 1.
REQ-029 A write to a non-busy register (e.g. debug) is legal and leaves busy unchanged.
REQ-030 alloc_err_o is registered, high for one cycle after an alloc to a register whose bit is 1 and is not clearing that cycle; the bit stays 1.
REQ-031 flush_i clears all busy bits at the next edge and overrides a same-cycle alloc; an in-flight output write still commits.
REQ-032 rsN_busy_o = busy[rsN_addr_i], combinational; reading register 0 always returns 0.

Reset
REQ-033 On rst_n low, immediately: busy=0, reg_write_o=0, rd_addr_o=0, write_data_o=0, alloc_err_o=0, last_grant=NREQ-1.
REQ-034 Reset mid-operation discards any accepted-but-uncommitted write; no write is issued after reset release until a new acceptance.

Structure
REQ-035 Shared defines file holds the requester index constants (LSU/ALU/DBG), register address width (5) and XLEN.
REQ-036 The round-robin picker is one sub-module, rr_arbiter (inputs: request vector, last_grant; output: one-hot grant), kept purely combinational.
REQ-037 The scoreboard and output register stay in regfile_wb_ctrl.

Verification
REQ-038 Single request: ALU valid, rd=5, data=0x12345678 -> ready[1] same cycle; next cycle reg_write_o=1, rd_addr_o=5, write_data_o=0x12345678.
REQ-039 Round-robin: all three valid continuously, first grant after reset -> grants 0,1,2,0 on consecutive cycles; no two ready bits high together.
REQ-040 Scoreboard: alloc rd=7; next cycle rs1_addr_i=7 -> rs1_busy_o=1; LSU writes rd=7 -> busy clears on the commit edge, so rs1_busy_o=0 the cycle after reg_write_o.
REQ-041 Collision: alloc rd=9 in the same cycle reg_write_o=1 for rd=9 -> busy[9] stays 1; a later alloc rd=9 while still busy -> alloc_err_o pulses for one cycle.
REQ-042 x0 and flush: request rd=0 -> handshake completes, reg_write_o stays 0; alloc rd=3 and rd=4, then flush_i -> both busy bits 0; a flush coinciding with alloc rd=6 -> busy[6]=0.
REQ-043 Reset mid-write: assert rst_n low in the cycle after acceptance -> reg_write_o=0 immediately, busy all 0.
